// File: rtl/store_outstanding_tracker_pkg.sv
// Shared types for the store outstanding tracker: FSM states, NI region rule
// record and the in-flight counter width helper.
package store_tracker_pkg;

    localparam int unsigned MaxAddrWidth = 64;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        DONE
    } tracker_state_e;

    typedef struct packed {
        logic [MaxAddrWidth-1:0] base;
        logic [MaxAddrWidth-1:0] length;
    } ni_rule_t;

    function automatic int unsigned cnt_width(input int unsigned max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/store_outstanding_tracker_if.sv
// Store issue / ack / fence bundle between the store unit commit stage and the tracker.
interface store_outstanding_tracker_if #(
    parameter int unsigned NrPorts    = 2,
    parameter int unsigned AddrWidth  = 64,
    parameter int unsigned NrAckPorts = 1,
    parameter int unsigned CntW       = 3
);

    logic [NrPorts-1:0]           st_valid_i;
    logic [NrPorts*AddrWidth-1:0] st_addr_i;
    logic [NrPorts-1:0]           st_ready_o;
    logic [NrPorts-1:0]           st_ni_o;
    logic [NrAckPorts-1:0]        ack_valid_i;
    logic                         fence_req_i;
    logic                         fence_done_o;
    logic [CntW-1:0]              outstanding_o;
    logic                         ni_pending_o;
    logic                         err_o;

    modport master (
        output st_valid_i, st_addr_i, ack_valid_i, fence_req_i,
        input  st_ready_o, st_ni_o, fence_done_o, outstanding_o, ni_pending_o, err_o
    );

    modport slave (
        input  st_valid_i, st_addr_i, ack_valid_i, fence_req_i,
        output st_ready_o, st_ni_o, fence_done_o, outstanding_o, ni_pending_o, err_o
    );

endinterface

// File: rtl/store_outstanding_tracker_ni_region_match.sv
// Classifies one physical address against the non-idempotent region rules.
module ni_region_match
    import store_tracker_pkg::*;
#(
    parameter int unsigned NrNIRules = 2
) (
    input  logic [MaxAddrWidth-1:0] addr,
    input  ni_rule_t [NrNIRules-1:0] rules,
    output logic                     hit
);

    // Offset compare avoids overflow of base+length at the top of the address space.
    always_comb begin
        hit = 1'b0;
        for (int unsigned r = 0; r < NrNIRules; r++) begin
            if ((rules[r].length != '0) && (addr >= rules[r].base) &&
                ((addr - rules[r].base) < rules[r].length)) begin
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/store_outstanding_tracker.sv
// Bounds in-flight stores, orders NI stores and drains on fence.
// Optional stall statistics counter enabled by STORE_TRACKER_STATS_EN.
module store_outstanding_tracker
    import store_tracker_pkg::*;
#(
    parameter int unsigned NrPorts        = 2,
    parameter int unsigned AddrWidth      = 64,
    parameter int unsigned MaxOutstanding = 7,
    parameter int unsigned NrAckPorts     = 1,
    parameter int unsigned NrNIRules      = 2,
    parameter logic [NrNIRules-1:0][AddrWidth-1:0] NIBase   = '0,
    parameter logic [NrNIRules-1:0][AddrWidth-1:0] NILength = '0
) (
    input  logic clk_i,
    input  logic rst_i,
    store_outstanding_tracker_if.slave bus
`ifdef STORE_TRACKER_STATS_EN
    ,
    output logic [31:0] stall_cycles_o
`endif
);

    localparam int unsigned CntW = cnt_width(MaxOutstanding);
    localparam int unsigned SumW = cnt_width(MaxOutstanding + NrPorts + NrAckPorts) + 1;

    tracker_state_e state_q, state_d;
    logic [CntW-1:0] count_q, count_d;
    logic            ni_pending_q, ni_pending_d;
    logic            err_q, err_d;
    logic            fence_done;

    ni_rule_t [NrNIRules-1:0] rules;
    logic [NrPorts-1:0]       ni;
    logic [NrPorts-1:0]       ready;
    logic [SumW-1:0]          granted, base, acks, total;
    logic                     chain_blocked, ni_granted, blocked;

    for (genvar r = 0; r < NrNIRules; r++) begin : g_rule
        assign rules[r].base   = MaxAddrWidth'(NIBase[r]);
        assign rules[r].length = MaxAddrWidth'(NILength[r]);
    end

    for (genvar p = 0; p < NrPorts; p++) begin : g_match
        ni_region_match #(
            .NrNIRules(NrNIRules)
        ) u_match (
            .addr (MaxAddrWidth'(bus.st_addr_i[p*AddrWidth +: AddrWidth])),
            .rules(rules),
            .hit  (ni[p])
        );
    end

    // In-order admission: a valid port that is refused also refuses every younger port.
    always_comb begin
        ready         = '0;
        granted       = '0;
        base          = '0;
        blocked       = 1'b0;
        chain_blocked = 1'b0;
        ni_granted    = 1'b0;
        for (int unsigned i = 0; i < NrPorts; i++) begin
            base    = SumW'(count_q) + granted;
            blocked = rst_i || (state_q != IDLE) || (base == SumW'(MaxOutstanding)) ||
                      ni_pending_q || (ni[i] && (base != '0)) || ni_granted || chain_blocked;
            ready[i] = !blocked;
            if (bus.st_valid_i[i]) begin
                if (!blocked) begin
                    granted = granted + SumW'(1);
                    if (ni[i]) ni_granted = 1'b1;
                end else begin
                    chain_blocked = 1'b1;
                end
            end
        end
    end

    always_comb begin
        acks = '0;
        for (int unsigned a = 0; a < NrAckPorts; a++) begin
            acks = acks + SumW'(bus.ack_valid_i[a]);
        end
        total = SumW'(count_q) + granted;
        err_d = err_q;
        if (acks > total) begin
            count_d = '0;
            err_d   = 1'b1;
        end else begin
            count_d = CntW'(total - acks);
        end
        ni_pending_d = (count_d != '0) && (ni_pending_q || ni_granted);
    end

    always_comb begin
        state_d    = state_q;
        fence_done = 1'b0;
        case (state_q)
            IDLE:    if (bus.fence_req_i) state_d = DRAIN;
            DRAIN:   if (count_q == '0) state_d = DONE;
            DONE: begin
                fence_done = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            count_q      <= '0;
            ni_pending_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            ni_pending_q <= ni_pending_d;
            err_q        <= err_d;
        end
    end

`ifdef STORE_TRACKER_STATS_EN
    logic [31:0] stall_q;
    logic        stall;

    assign stall = |(bus.st_valid_i & ~ready);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_q <= '0;
        end else if (stall && (stall_q != '1)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles_o = stall_q;
`endif

    assign bus.st_ready_o    = ready;
    assign bus.st_ni_o       = ni;
    assign bus.fence_done_o  = fence_done;
    assign bus.outstanding_o = count_q;
    assign bus.ni_pending_o  = ni_pending_q;
    assign bus.err_o         = err_q;

endmodule

// File: tb/tb_store_outstanding_tracker.sv
// Scoreboard bench for store_outstanding_tracker: directed scenarios then random traffic.
module tb_store_outstanding_tracker;

    localparam int unsigned NP   = 2;
    localparam int unsigned AW   = 64;
    localparam int unsigned MAXO = 7;
    localparam int unsigned NA   = 1;
    localparam int unsigned NR   = 2;
    localparam int unsigned CW   = 3;
    localparam logic [NR-1:0][AW-1:0] NI_BASE = {64'h0000_0000_2000_0000, 64'h0000_0000_1000_0000};
    localparam logic [NR-1:0][AW-1:0] NI_LEN  = {64'h0000_0000_0000_0010, 64'h0000_0000_0000_1000};

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    store_outstanding_tracker_if #(.NrPorts(NP), .AddrWidth(AW), .NrAckPorts(NA), .CntW(CW)) bus ();

`ifdef STORE_TRACKER_STATS_EN
    logic [31:0] stall_cycles;
`endif

    store_outstanding_tracker #(
        .NrPorts(NP), .AddrWidth(AW), .MaxOutstanding(MAXO), .NrAckPorts(NA),
        .NrNIRules(NR), .NIBase(NI_BASE), .NILength(NI_LEN)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
`ifdef STORE_TRACKER_STATS_EN
        .stall_cycles_o(stall_cycles),
`endif
        .bus(bus)
    );

    typedef struct {
        logic [1:0]  ready;
        logic [1:0]  ni;
        int          outstanding;
        bit          nip;
        bit          err;
        bit          done;
        int unsigned stall;
    } exp_t;

    exp_t sb[$];

    // Reference state, kept at transaction level.
    int          m_count = 0;
    bit          m_nip   = 0;
    bit          m_err   = 0;
    int          m_stage = 0;
    int unsigned m_stall = 0;
    bit          last_done = 0;
    bit          fence_on  = 0;

    logic [63:0] r_base[2] = '{64'h1000_0000, 64'h2000_0000};
    logic [63:0] r_len[2]  = '{64'h1000, 64'h10};
    logic [63:0] edges[9]  = '{64'h0FFF_FFF8, 64'h1000_0000, 64'h1000_0FFF, 64'h1000_1000,
                               64'h1FFF_FFFF, 64'h2000_0000, 64'h2000_000F, 64'h2000_0010,
                               64'hFFFF_FFFF_FFFF_FFFF};

    function automatic bit is_ni(input logic [63:0] a);
        for (int r = 0; r < 2; r++) begin
            if (r_len[r] != 0 && a >= r_base[r] && a < r_base[r] + r_len[r]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [63:0] pick_addr();
        case ($urandom_range(0, 9))
            0, 1:    return 64'h1000_0000 + 64'($urandom_range(0, 511) * 8);
            2:       return edges[$urandom_range(0, 8)];
            3:       return {$urandom, $urandom};
            default: return {32'h0, $urandom} & 64'h0000_0000_0FFF_FFF8;
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle of stimulus; the reference computes this cycle's outputs, then advances.
    task automatic step(input bit r, input logic [1:0] v, input logic [63:0] a0,
                        input logic [63:0] a1, input logic ack, input logic fence);
        exp_t e;
        int   taken, inflight, nxt;
        bit   ni_taken, stopped, ok;
        @(posedge clk);
        #2;
        rst              = r;
        bus.st_valid_i   = v;
        bus.st_addr_i    = {a1, a0};
        bus.ack_valid_i  = ack;
        bus.fence_req_i  = fence;
        e.ni[0] = is_ni(a0);
        e.ni[1] = is_ni(a1);
        if (r) begin
            m_count = 0; m_nip = 0; m_err = 0; m_stage = 0; m_stall = 0;
        end
        e.outstanding = m_count;
        e.nip         = m_nip;
        e.err         = m_err;
        e.done        = (m_stage == 2);
        e.stall       = m_stall;
        e.ready       = '0;
        last_done     = e.done;
        if (!r) begin
            taken = 0; ni_taken = 0; stopped = 0;
            for (int p = 0; p < int'(NP); p++) begin
                inflight = m_count + taken;
                ok = (m_stage == 0) && !m_nip && (inflight < int'(MAXO)) &&
                     !(e.ni[p] && inflight != 0) && !ni_taken && !stopped;
                e.ready[p] = ok;
                if (v[p]) begin
                    if (ok) begin
                        taken++;
                        if (e.ni[p]) ni_taken = 1;
                    end else begin
                        stopped = 1;
                    end
                end
            end
            if (stopped && m_stall != 32'hFFFF_FFFF) m_stall++;
            nxt = m_count + taken - int'(ack);
            if (nxt < 0) begin
                nxt   = 0;
                m_err = 1;
            end
            m_nip = (nxt != 0) && (m_nip || ni_taken);
            case (m_stage)
                0:       if (fence) m_stage = 1;
                1:       if (m_count == 0) m_stage = 2;
                default: m_stage = 0;
            endcase
            m_count = nxt;
        end
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("st_ready", 64'(bus.st_ready_o), 64'(e.ready));
            chk("st_ni", 64'(bus.st_ni_o), 64'(e.ni));
            chk("outstanding", 64'(bus.outstanding_o), 64'(e.outstanding));
            chk("ni_pending", 64'(bus.ni_pending_o), 64'(e.nip));
            chk("err", 64'(bus.err_o), 64'(e.err));
            chk("fence_done", 64'(bus.fence_done_o), 64'(e.done));
`ifdef STORE_TRACKER_STATS_EN
            chk("stall_cycles", 64'(stall_cycles), 64'(e.stall));
`endif
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    localparam logic [63:0] IA  = 64'h0000_0000_0000_0100;
    localparam logic [63:0] NIA = 64'h0000_0000_1000_0008;

    initial begin
        int  k;
        bit  seen;
        bus.st_valid_i  = '0;
        bus.st_addr_i   = '0;
        bus.ack_valid_i = '0;
        bus.fence_req_i = 1'b0;

        repeat (2) step(1, 2'b00, IA, IA, 0, 0);
        @(negedge clk);
        chk("reset_ready", 64'(bus.st_ready_o), 64'd0);
        chk("reset_outstanding", 64'(bus.outstanding_o), 64'd0);

        // Fill to the limit on port 0.
        repeat (10) step(0, 2'b01, IA, IA, 0, 0);
        @(negedge clk);
        chk("t1_outstanding", 64'(bus.outstanding_o), 64'd7);
        chk("t1_ready0", 64'(bus.st_ready_o[0]), 64'd0);

        // One slot left, both ports request.
        step(0, 2'b00, IA, IA, 1, 0);
        step(0, 2'b11, IA, IA, 0, 0);
        @(negedge clk);
        chk("t2_ready", 64'(bus.st_ready_o), 64'd1);
        step(0, 2'b00, IA, IA, 0, 0);
        @(negedge clk);
        chk("t2_outstanding", 64'(bus.outstanding_o), 64'd7);

        // Drain, then ack at zero, then grant+ack netting out.
        repeat (8) step(0, 2'b00, IA, IA, 1, 0);
        step(0, 2'b00, IA, IA, 0, 0);
        @(negedge clk);
        chk("t5_err", 64'(bus.err_o), 64'd1);
        chk("t5_zero", 64'(bus.outstanding_o), 64'd0);
        repeat (4) step(0, 2'b01, IA, IA, 0, 0);
        step(0, 2'b01, IA, IA, 1, 0);
        step(0, 2'b00, IA, IA, 0, 0);
        @(negedge clk);
        chk("t5_net", 64'(bus.outstanding_o), 64'd4);
        chk("t5_err_sticky", 64'(bus.err_o), 64'd1);

        // NI ordering.
        step(1, 2'b00, IA, IA, 0, 0);
        repeat (2) step(0, 2'b01, IA, IA, 0, 0);
        step(0, 2'b01, NIA, IA, 1, 0);
        @(negedge clk);
        chk("t3_ni_stall", 64'(bus.st_ready_o[0]), 64'd0);
        step(0, 2'b01, NIA, IA, 1, 0);
        step(0, 2'b01, NIA, IA, 0, 0);
        @(negedge clk);
        chk("t3_ni_grant", 64'(bus.st_ready_o[0]), 64'd1);
        step(0, 2'b01, IA, IA, 0, 0);
        @(negedge clk);
        chk("t3_ni_pending", 64'(bus.ni_pending_o), 64'd1);
        chk("t3_idem_stall", 64'(bus.st_ready_o[0]), 64'd0);
        step(0, 2'b01, IA, IA, 1, 0);
        step(0, 2'b01, IA, IA, 0, 0);
        @(negedge clk);
        chk("t3_idem_after_ack", 64'(bus.st_ready_o[0]), 64'd1);

        // Fence with three outstanding stores.
        repeat (2) step(0, 2'b01, IA, IA, 0, 0);
        k = 0;
        seen = 0;
        while (!seen && k < 20) begin
            step(0, (k == 0) ? 2'b00 : 2'b11, IA, IA, (k < 5) ? logic'(k % 2 == 0) : 1'b0, 1);
            @(negedge clk);
            seen = bus.fence_done_o;
            k++;
        end
        chk("t4_done_seen", 64'(seen), 64'd1);
        step(0, 2'b00, IA, IA, 0, 0);
        @(negedge clk);
        chk("t4_done_pulse", 64'(bus.fence_done_o), 64'd0);

        // Reset in the middle of a drain.
        repeat (2) step(0, 2'b01, IA, IA, 0, 0);
        repeat (2) step(0, 2'b01, IA, IA, 0, 1);
        step(1, 2'b01, IA, IA, 0, 1);
        step(0, 2'b01, IA, IA, 0, 0);
        @(negedge clk);
        chk("t6_ready_idle", 64'(bus.st_ready_o[0]), 64'd1);
        chk("t6_outstanding", 64'(bus.outstanding_o), 64'd0);
        step(0, 2'b00, IA, IA, 1, 0);
        step(0, 2'b00, IA, IA, 1, 0);

`ifdef STORE_TRACKER_STATS_EN
        step(1, 2'b00, IA, IA, 0, 0);
        repeat (12) step(0, 2'b01, IA, IA, 0, 0);
        step(0, 2'b00, IA, IA, 0, 0);
        @(negedge clk);
        chk("t6_stall5", 64'(stall_cycles), 64'd5);
`endif

        // Random traffic.
        fence_on = 0;
        for (int n = 0; n < 3000; n++) begin
            bit         r;
            logic [1:0] v;
            logic       ack;
            r    = ($urandom_range(0, 249) == 0);
            v[0] = ($urandom_range(0, 9) < 6);
            v[1] = ($urandom_range(0, 9) < 6);
            if (m_count > 0) ack = ($urandom_range(0, 9) < 4);
            else             ack = ($urandom_range(0, 39) == 0);
            if (!fence_on && $urandom_range(0, 59) == 0) fence_on = 1;
            step(r, v, pick_addr(), pick_addr(), ack, fence_on);
            if (r) fence_on = 0;
            else if (last_done && $urandom_range(0, 1) == 0) fence_on = 0;
        end

        step(0, 2'b00, IA, IA, 0, 0);
        k = 0;
        while (sb.size() != 0 && k < 5) begin
            @(negedge clk);
            k++;
        end
        #1;
        if (sb.size() != 0) chk("sb_drain", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
